// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: shared SimpleRISC definitions for the decode stage.
//   - opcode and immediate-modifier codes
//   - RA_IDX (return-address register) and the canonical NOP encoding
//   - de_reg_t: contents of the D/E pipeline register
//   - imm_ext(): immediate generation from modifier + imm16
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_ZEXT = 2'b01;
  localparam logic [1:0] MOD_HIGH = 2'b10;
  localparam logic [1:0] MOD_RSVD = 2'b11;  // decodes like MOD_SEXT

  localparam logic [3:0]  RA_IDX       = 4'd15;
  localparam logic [31:0] NOP_INSTR    = 32'h6800_0000;
  localparam int          NUM_REGS     = 16;
  localparam int          NUM_RD_PORTS = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] st_data;
    logic [31:0] branch_target;
    logic [3:0]  rd;
    logic [4:0]  aluop;
    logic        is_ld;
    logic        is_st;
    logic        is_beq;
    logic        is_bgt;
    logic        is_ubr;
    logic        is_ret;
    logic        is_call;
    logic        is_wb;
    logic        is_imm;
  } de_reg_t;

  function automatic logic [31:0] imm_ext(input logic [1:0] modifier, input logic [15:0] imm16);
    case (modifier)
      MOD_ZEXT: imm_ext = {16'h0, imm16};
      MOD_HIGH: imm_ext = {imm16, 16'h0};
      default:  imm_ext = {{16{imm16[15]}}, imm16};
    endcase
  endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// decode_cycle_if: fetch->decode inputs, writeback port, hazard-unit read
// addresses and the registered D/E outputs of the decode stage.
//   master : fetch/writeback side (drives *_D, stall/flush, *_W)
//   slave  : decode stage (drives rs1_D/rs2_D and all *_E)
interface decode_cycle_if;
  logic [31:0] instruction_D;
  logic [31:0] pc_D;
  logic        stall_D;
  logic        isbranchtaken_E;
  logic        we_W;
  logic [3:0]  rd_W;
  logic [31:0] result_W;

  logic [3:0]  rs1_D;
  logic [3:0]  rs2_D;

  logic        valid_E;
  logic [31:0] pc_E;
  logic [31:0] op1_E;
  logic [31:0] op2_E;
  logic [31:0] st_data_E;
  logic [31:0] branch_target_E;
  logic [3:0]  rd_E;
  logic [4:0]  aluop_E;
  logic        is_ld_E, is_st_E, is_beq_E, is_bgt_E, is_ubr_E;
  logic        is_ret_E, is_call_E, is_wb_E, is_imm_E;

  modport master (
    output instruction_D, pc_D, stall_D, isbranchtaken_E, we_W, rd_W, result_W,
    input  rs1_D, rs2_D, valid_E, pc_E, op1_E, op2_E, st_data_E, branch_target_E,
           rd_E, aluop_E, is_ld_E, is_st_E, is_beq_E, is_bgt_E, is_ubr_E,
           is_ret_E, is_call_E, is_wb_E, is_imm_E
  );

  modport slave (
    input  instruction_D, pc_D, stall_D, isbranchtaken_E, we_W, rd_W, result_W,
    output rs1_D, rs2_D, valid_E, pc_E, op1_E, op2_E, st_data_E, branch_target_E,
           rd_E, aluop_E, is_ld_E, is_st_E, is_beq_E, is_bgt_E, is_ubr_E,
           is_ret_E, is_call_E, is_wb_E, is_imm_E
  );
endinterface

// File: rtl/decode_cycle_register_file.sv
// register_file: 16x32 register file, NUM_RD_PORTS combinational read ports,
// one synchronous write port. Synchronous active-low reset clears all entries.
// Optional macro DECODE_RF_BYPASS_EN: a same-cycle write is forwarded to any
// read port addressing the register being written; otherwise reads return
// the pre-write value.
//   clk, rst        : clock, sync active-low reset
//   i_we/i_waddr/i_wdata : write port
//   i_raddr/o_rdata : read ports (port 0 = rs1, port 1 = rs2)
module register_file
  import simplerisc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_we,
  input  logic [3:0]                     i_waddr,
  input  logic [31:0]                    i_wdata,
  input  logic [NUM_RD_PORTS-1:0][3:0]   i_raddr,
  output logic [NUM_RD_PORTS-1:0][31:0]  o_rdata
);

  logic [NUM_REGS-1:0][31:0] r_regs;

  // Reset takes priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (!rst)      r_regs <= '0;
    else if (i_we) r_regs[i_waddr] <= i_wdata;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
`ifdef DECODE_RF_BYPASS_EN
    assign o_rdata[p] = (i_we && (i_waddr == i_raddr[p])) ? i_wdata : r_regs[i_raddr[p]];
`else
    assign o_rdata[p] = r_regs[i_raddr[p]];
`endif
  end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: SimpleRISC decode stage with D/E pipeline register.
//   clk, rst : clock, synchronous active-low reset (bubble + RF clear)
//   dc       : decode_cycle_if.slave -- fetch inputs, stall/flush, writeback
//              port, rs1_D/rs2_D (combinational), *_E (registered)
// Config macro: DECODE_RF_BYPASS_EN (write->read forwarding in register_file).
module decode_cycle
  import simplerisc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave dc
);

  logic                          w_rsvd, w_squash;
  logic [31:0]                   w_instr;
  logic [4:0]                    w_op;
  logic [3:0]                    w_rs1, w_rs2;
  logic [NUM_RD_PORTS-1:0][3:0]  w_raddr;
  logic [NUM_RD_PORTS-1:0][31:0] w_rdata;
  logic [31:0]                   w_imm;
  de_reg_t                       w_de, r_de;

  // Reserved opcodes and flushed slots are both decoded as the canonical NOP;
  // only the valid bit tells them apart from a real nop.
  assign w_rsvd   = dc.instruction_D[31:27] > OP_RET;
  assign w_squash = dc.isbranchtaken_E | w_rsvd;
  assign w_instr  = w_squash ? NOP_INSTR : dc.instruction_D;
  assign w_op     = w_instr[31:27];

  // ret reads the return address; st reads its data register from the rd field.
  assign w_rs1   = (w_op == OP_RET) ? RA_IDX : w_instr[21:18];
  assign w_rs2   = (w_op == OP_ST)  ? w_instr[25:22] : w_instr[17:14];
  assign w_raddr = {w_rs2, w_rs1};
  assign w_imm   = imm_ext(w_instr[17:16], w_instr[15:0]);

  assign dc.rs1_D = w_rs1;
  assign dc.rs2_D = w_rs2;

  register_file u_rf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (dc.we_W),
    .i_waddr (dc.rd_W),
    .i_wdata (dc.result_W),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_de               = '0;
    w_de.valid         = ~w_squash;
    w_de.pc            = dc.pc_D;
    w_de.op1           = w_rdata[0];
    w_de.is_imm        = w_instr[26] & (w_op != OP_NOP);
    w_de.op2           = w_de.is_imm ? w_imm : w_rdata[1];
    w_de.st_data       = w_rdata[1];
    w_de.branch_target = dc.pc_D + ({{5{w_instr[26]}}, w_instr[26:0]} << 2);
    w_de.rd            = (w_op == OP_CALL) ? RA_IDX : w_instr[25:22];
    // Non-ALU instructions (ld/st address calc, branches) use ADD.
    w_de.aluop         = (w_op <= OP_ASR) ? w_op : OP_ADD;
    w_de.is_ld         = (w_op == OP_LD);
    w_de.is_st         = (w_op == OP_ST);
    w_de.is_beq        = (w_op == OP_BEQ);
    w_de.is_bgt        = (w_op == OP_BGT);
    w_de.is_ret        = (w_op == OP_RET);
    w_de.is_call       = (w_op == OP_CALL);
    w_de.is_ubr        = (w_op == OP_B) | (w_op == OP_CALL) | (w_op == OP_RET);
    case (w_op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOT,
      OP_MOV, OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_CALL: w_de.is_wb = 1'b1;
      default:                                        w_de.is_wb = 1'b0;
    endcase
  end

  // Flush beats stall: a flushed slot always loads the bubble.
  always_ff @(posedge clk) begin
    if (!rst)                                   r_de <= '0;
    else if (dc.isbranchtaken_E || !dc.stall_D) r_de <= w_de;
  end

  assign dc.valid_E         = r_de.valid;
  assign dc.pc_E            = r_de.pc;
  assign dc.op1_E           = r_de.op1;
  assign dc.op2_E           = r_de.op2;
  assign dc.st_data_E       = r_de.st_data;
  assign dc.branch_target_E = r_de.branch_target;
  assign dc.rd_E            = r_de.rd;
  assign dc.aluop_E         = r_de.aluop;
  assign dc.is_ld_E         = r_de.is_ld;
  assign dc.is_st_E         = r_de.is_st;
  assign dc.is_beq_E        = r_de.is_beq;
  assign dc.is_bgt_E        = r_de.is_bgt;
  assign dc.is_ubr_E        = r_de.is_ubr;
  assign dc.is_ret_E        = r_de.is_ret;
  assign dc.is_call_E       = r_de.is_call;
  assign dc.is_wb_E         = r_de.is_wb;
  assign dc.is_imm_E        = r_de.is_imm;

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-low (rst==0 sampled at posedge clk resets).
REQ-003 SHALL have inputs instruction_D[31:0] and pc_D[31:0] from the fetch stage.
REQ-004 SHALL have inputs stall_D (1, hold), isbranchtaken_E (1, flush) and we_W (1), rd_W[3:0], result_W[31:0] (writeback port).
REQ-005 SHALL have combinational outputs rs1_D[3:0], rs2_D[3:0], the read addresses for the hazard unit.
REQ-006 SHALL have registered outputs valid_E, pc_E[31:0], op1_E[31:0], op2_E[31:0], st_data_E[31:0], branch_target_E[31:0], rd_E[3:0], aluop_E[4:0], is_ld_E, is_st_E, is_beq_E, is_bgt_E, is_ubr_E, is_ret_E, is_call_E, is_wb_E, is_imm_E.

Function
REQ-007 SHALL decode opcode=[31:27], I=[26], rd=[25:22], rs1=[21:18], rs2=[17:14], modifier=[17:16], imm16=[15:0], offset27=[26:0].
REQ-008 SHALL read rs1_D from the rs1 field, or r15 for ret (10100).
REQ-009 SHALL read rs2_D from the rd field for st (01111), else from the rs2 field.
REQ-010 SHALL form the immediate as follows: modifier 00 sign-extends imm16, 01 zero-extends it, 10 gives {imm16,16'h0}, and 11 behaves as 00.
REQ-011 SHALL drive op2_E with the immediate when I=1, else with the reg[rs2] read; st_data_E SHALL always carry reg[rs2_D].
REQ-012 SHALL compute branch_target_E = pc_D + ({{5{offset27[26]}},offset27} << 2), truncated to 32 bits with wrap-around allowed.
REQ-013 SHALL set rd_E to r15 for call (10011), else to the rd field; is_wb_E SHALL be 1 for opcodes 00000-00100, 00110-01100, 01110 and 10011.
REQ-014 SHALL treat opcodes 10101-11111 as nop with valid_E=0; nop (01101) SHALL give valid_E=1 with all is_* flags 0.
REQ-015 SHALL have a latency of one cycle: the decode of instruction_D at edge n appears on *_E after edge n.
REQ-016 SHALL, when stall_D=1 and isbranchtaken_E=0, hold all *_E outputs and ignore instruction_D.
REQ-017 SHALL, when isbranchtaken_E=1, load a bubble on the next edge: valid_E=0, all is_* flags 0, instruction taken as nop; flush SHALL override a simultaneous stall_D.
REQ-018 SHALL contain a 16x32 register file with 2 combinational read ports and 1 synchronous write port (we_W, rd_W, result_W); writes SHALL proceed during stall and flush.

Reset
REQ-019 SHALL, while rst==0 at a posedge, clear all 16 registers and load a bubble: valid_E=0, all *_E buses 0, all flags 0.
REQ-020 SHALL let a reset asserted mid-stall or mid-flush override both; the first post-reset cycle SHALL decode instruction_D normally.

Configuration
REQ-021 SHALL, when macro DECODE_RF_BYPASS_EN is defined, forward result_W to a read port in the same cycle if we_W=1 and rd_W equals that read address.
REQ-022 SHALL, when DECODE_RF_BYPASS_EN is undefined, return the pre-write register value on a same-cycle read, leaving the hazard unit to stall one extra cycle.

Structure
REQ-023 SHALL define opcode localparams (ADD..RET), modifier codes, RA_IDX=15 and the NOP_INSTR=32'h6800_0000 constant in shared package simplerisc_pkg.
REQ-024 SHALL implement the register storage, the reset clear and the bypass in sub-module register_file; decode and the D/E pipeline register stay in decode_cycle.

Verification
REQ-025 SHALL cover add r3,r1,r2 with r1=5, r2=7: op1_E=5, op2_E=7, rd_E=3, is_wb_E=1, aluop_E=00000, one cycle later.
REQ-026 SHALL cover mov with modifier 10 and imm16=16'h1234: op2_E=32'h1234_0000, is_imm_E=1; with modifier 00 and imm16=16'hFFFF: op2_E=32'hFFFF_FFFF.
REQ-027 SHALL cover call with pc_D=32'h100 and offset27=-4: branch_target_E=32'hF0, rd_E=15, is_call_E=1.
REQ-028 SHALL cover stall_D=1 for 3 cycles with changing instruction_D (*_E unchanged), then isbranchtaken_E=1 together with stall_D=1 (valid_E=0 next cycle).
REQ-029 SHALL cover we_W=1, rd_W=4, result_W=32'hAA with rs1=4 in the same cycle: op1_E=32'hAA with DECODE_RF_BYPASS_EN, and the old value without it.
REQ-030 SHALL cover rst=0 mid-operation for one cycle: valid_E=0 and all registers read 0 afterwards; ret then yields op1_E=r15=0.
